// File: rtl/dvp_rgb565_tx.sv
// Synthetic OV5640-style DVP source: emits RGB565 test patterns as an 8-bit
// parallel stream (vsync/href/data) with one byte per clk, high byte first.
module dvp_rgb565_tx #(
  parameter int H_ACTIVE    = 480,
  parameter int V_ACTIVE    = 272,
  parameter int H_BLANK     = 64,
  parameter int VS_LINES    = 2,
  parameter int V_BACK      = 4,
  parameter int V_FRONT     = 4,
  parameter int CHECK_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [7:0]  cmos_db,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam int HTOTAL = 2 * H_ACTIVE + H_BLANK;
  localparam int VTOTAL = VS_LINES + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW     = $clog2(HTOTAL + 1);
  localparam int VW     = $clog2(VTOTAL + 1);
  localparam int BAR_W  = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [HW-1:0] H_LAST    = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(2 * H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] VS_END    = VW'(VS_LINES);
  localparam logic [VW-1:0] V_ACT_BEG = VW'(VS_LINES + V_BACK);
  localparam logic [VW-1:0] V_ACT_END = VW'(VS_LINES + V_BACK + V_ACTIVE);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic          w_start;
  logic          w_run;
  logic          w_last;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic [1:0]    r_mode;
  logic [15:0]   r_solid;
  logic          r_done;
  logic [15:0]   r_frame_cnt;

  logic [15:0]   w_x;
  logic [15:0]   w_y;
  logic [15:0]   w_bar;
  logic [2:0]    w_bar_idx;
  logic [15:0]   w_pix;
  logic [7:0]    w_byte;
  logic          w_vsync;
  logic          w_href;

  assign w_run  = (r_state == S_RUN);
  assign w_last = (r_h == H_LAST) && (r_v == V_LAST);

  // en is only looked at in IDLE and on the last clock of a frame, so a frame
  // in flight always runs to completion.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_next = S_RUN;
          w_start      = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) begin
          if (en) w_start = 1'b1;
          else    w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_h     <= '0;
      r_v     <= '0;
      r_mode  <= 2'd0;
      r_solid <= 16'h0000;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_h     <= '0;
        r_v     <= '0;
        r_mode  <= mode;
        r_solid <= solid_color;
      end else if (w_run) begin
        if (r_h == H_LAST) begin
          r_h <= '0;
          r_v <= (r_v == V_LAST) ? '0 : r_v + VW'(1);
        end else begin
          r_h <= r_h + HW'(1);
        end
      end
    end
  end

  always_comb begin
    w_x       = 16'(r_h >> 1);
    w_y       = 16'(r_v) - 16'(V_ACT_BEG);
    w_bar     = w_x / 16'(BAR_W);
    w_bar_idx = (w_bar > 16'd7) ? 3'd7 : w_bar[2:0];
    w_pix     = 16'h0000;
    case (r_mode)
      2'd0: begin
        case (w_bar_idx)
          3'd0:    w_pix = 16'hFFFF;
          3'd1:    w_pix = 16'hFFE0;
          3'd2:    w_pix = 16'h07FF;
          3'd3:    w_pix = 16'h07E0;
          3'd4:    w_pix = 16'hF81F;
          3'd5:    w_pix = 16'hF800;
          3'd6:    w_pix = 16'h001F;
          default: w_pix = 16'h0000;
        endcase
      end
      2'd1:    w_pix = {w_x[4:0], w_x[5:0], w_x[4:0]};
      2'd2:    w_pix = r_solid;
      default: w_pix = ((((w_x ^ w_y) >> CHECK_SHIFT) & 16'd1) != 16'd0) ? 16'hFFFF : 16'h0000;
    endcase
    w_byte  = r_h[0] ? w_pix[7:0] : w_pix[15:8];
    w_vsync = w_run && (r_v < VS_END);
    w_href  = w_run && (r_v >= V_ACT_BEG) && (r_v < V_ACT_END) && (r_h < H_ACT_END);
  end

  // Outputs trail the counters by one clock; the frame count follows the
  // registered end-of-frame flag so it moves together with busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmos_vsync  <= 1'b0;
      cmos_href   <= 1'b0;
      cmos_db     <= 8'h00;
      busy        <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= 16'h0000;
    end else begin
      cmos_vsync <= w_vsync;
      cmos_href  <= w_href;
      cmos_db    <= w_href ? w_byte : 8'h00;
      busy       <= w_run;
      r_done     <= w_run && w_last;
      if (r_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_dvp_rgb565_tx.sv
// Directed and randomized bench for dvp_rgb565_tx using a frame-level
// reference model indexed by clock-within-frame.
module tb_dvp_rgb565_tx;

  localparam int HA = 8;
  localparam int VA = 4;
  localparam int HB = 4;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VF = 1;
  localparam int CS = 2;
  localparam int HT = 2 * HA + HB;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_db;
  logic [15:0] frame_cnt;
  logic        busy;

  int          n_vec;
  int          n_fail;
  logic [15:0] exp_cnt;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  bar_line[16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                 8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

  dvp_rgb565_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB), .VS_LINES(VS),
    .V_BACK(VB), .V_FRONT(VF), .CHECK_SHIFT(CS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_color(solid_color),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_db(cmos_db),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] model_pixel(input int x, input int y, input int md,
                                               input logic [15:0] sc);
    logic [15:0] xv;
    logic [15:0] px;
    int          bar;
    xv = 16'(x);
    px = 16'h0000;
    case (md)
      0: begin
        bar = x / (HA / 8);
        if (bar > 7) bar = 7;
        case (bar)
          0:       px = 16'hFFFF;
          1:       px = 16'hFFE0;
          2:       px = 16'h07FF;
          3:       px = 16'h07E0;
          4:       px = 16'hF81F;
          5:       px = 16'hF800;
          6:       px = 16'h001F;
          default: px = 16'h0000;
        endcase
      end
      1:       px = {xv[4:0], xv[5:0], xv[4:0]};
      2:       px = sc;
      default: px = ((((x >> CS) ^ (y >> CS)) % 2) != 0) ? 16'hFFFF : 16'h0000;
    endcase
    return px;
  endfunction

  function automatic bit model_href(input int k);
    int h;
    int v;
    h = k % HT;
    v = k / HT;
    return (v >= VS + VB) && (v < VS + VB + VA) && (h < 2 * HA);
  endfunction

  function automatic logic [7:0] model_byte(input int k, input int md, input logic [15:0] sc);
    logic [15:0] px;
    int          h;
    h  = k % HT;
    px = model_pixel(h / 2, k / HT - (VS + VB), md, sc);
    return (h % 2 == 1) ? px[7:0] : px[15:8];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, " vsync"}, 16'(cmos_vsync), 16'd0);
    check({tag, " href"},  16'(cmos_href),  16'd0);
    check({tag, " db"},    16'(cmos_db),    16'd0);
    check({tag, " busy"},  16'(busy),       16'd0);
    check({tag, " frame_cnt"}, frame_cnt,   exp_cnt);
  endtask

  task automatic start_frame(input logic [1:0] md, input logic [15:0] sc, input logic hold_en);
    mode        = md;
    solid_color = sc;
    en          = 1'b1;
    tick();
    en = hold_en;
  endtask

  // Checks one whole frame clock by clock; at sample chg_k the inputs are
  // changed to the *_n values (chg_k < 0 leaves them alone).
  task automatic frame_check(input int md, input logic [15:0] sc, input int chg_k,
                             input logic en_n, input logic [1:0] md_n, input logic [15:0] sc_n);
    exp_q.delete();
    got_q.delete();
    for (int k = 0; k < FT; k++)
      if (model_href(k)) exp_q.push_back(model_byte(k, md, sc));
    for (int k = 0; k < FT; k++) begin
      tick();
      check($sformatf("vsync k=%0d", k), 16'(cmos_vsync), 16'((k / HT) < VS));
      check($sformatf("href k=%0d", k),  16'(cmos_href),  16'(model_href(k)));
      check($sformatf("busy k=%0d", k),  16'(busy),       16'd1);
      check($sformatf("frame_cnt k=%0d", k), frame_cnt, exp_cnt);
      if (cmos_href === 1'b1) begin
        got_q.push_back(cmos_db);
        if (exp_q.size() > 0) check($sformatf("db k=%0d", k), 16'(cmos_db), 16'(exp_q.pop_front()));
      end else begin
        check($sformatf("db blank k=%0d", k), 16'(cmos_db), 16'd0);
      end
      if (k == chg_k) begin
        en          = en_n;
        mode        = md_n;
        solid_color = sc_n;
      end
    end
    check("bytes per frame", 16'(got_q.size()), 16'(2 * HA * VA));
    check("expected bytes left", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    logic [1:0]  cur_md;
    logic [1:0]  nxt_md;
    logic [15:0] cur_sc;
    logic [15:0] nxt_sc;
    n_vec       = 0;
    n_fail      = 0;
    exp_cnt     = 16'h0000;
    rst_n       = 1'b0;
    en          = 1'b0;
    mode        = 2'd0;
    solid_color = 16'h0000;

    repeat (5) tick();
    check_idle("reset");
    rst_n = 1'b1;
    repeat (300) begin
      tick();
      check_idle("idle");
    end

    // Colour bars from a one-clock en pulse.
    start_frame(2'd0, 16'h0000, 1'b0);
    frame_check(0, 16'h0000, -1, 1'b0, 2'd0, 16'h0000);
    exp_cnt++;
    if (got_q.size() == 2 * HA * VA)
      for (int i = 0; i < 2 * HA * VA; i++)
        check($sformatf("bar byte %0d", i), 16'(got_q[i]), 16'(bar_line[i % 16]));
    tick();
    check_idle("after bars");

    // Gradient: pixel 3 is 18 63 and pixel 7 is 38 E7 on every line.
    start_frame(2'd1, 16'h0000, 1'b0);
    frame_check(1, 16'h0000, -1, 1'b0, 2'd1, 16'h0000);
    exp_cnt++;
    if (got_q.size() == 2 * HA * VA)
      for (int l = 0; l < VA; l++) begin
        check($sformatf("grad x3 hi l%0d", l), 16'(got_q[l*16+6]),  16'h0018);
        check($sformatf("grad x3 lo l%0d", l), 16'(got_q[l*16+7]),  16'h0063);
        check($sformatf("grad x7 hi l%0d", l), 16'(got_q[l*16+14]), 16'h0038);
        check($sformatf("grad x7 lo l%0d", l), 16'(got_q[l*16+15]), 16'h00E7);
      end
    tick();
    check_idle("after gradient");

    // Checker: 8 bytes of 00 then 8 bytes of FF on each line.
    start_frame(2'd3, 16'h0000, 1'b0);
    frame_check(3, 16'h0000, -1, 1'b0, 2'd3, 16'h0000);
    exp_cnt++;
    if (got_q.size() == 2 * HA * VA)
      for (int i = 0; i < 2 * HA * VA; i++)
        check($sformatf("checker byte %0d", i), 16'(got_q[i]), ((i % 16) < 8) ? 16'h0000 : 16'h00FF);
    tick();
    check_idle("after checker");

    // Solid with mid-frame colour/mode change and en drop at clock 50.
    start_frame(2'd2, 16'h1234, 1'b1);
    frame_check(2, 16'h1234, 50, 1'b0, 2'd1, 16'hABCD);
    exp_cnt++;
    if (got_q.size() == 2 * HA * VA)
      for (int i = 0; i < 2 * HA * VA; i++)
        check($sformatf("solid1 byte %0d", i), 16'(got_q[i]), (i % 2 == 1) ? 16'h0034 : 16'h0012);
    tick();
    check_idle("after solid1");
    start_frame(2'd2, 16'hABCD, 1'b0);
    frame_check(2, 16'hABCD, -1, 1'b0, 2'd2, 16'hABCD);
    exp_cnt++;
    if (got_q.size() == 2 * HA * VA)
      for (int i = 0; i < 2 * HA * VA; i++)
        check($sformatf("solid2 byte %0d", i), 16'(got_q[i]), (i % 2 == 1) ? 16'h00CD : 16'h00AB);
    tick();
    check_idle("after solid2");

    // Three back-to-back frames with no gap.
    start_frame(2'd0, 16'h0000, 1'b1);
    frame_check(0, 16'h0000, -1, 1'b1, 2'd0, 16'h0000);
    exp_cnt++;
    frame_check(0, 16'h0000, -1, 1'b1, 2'd0, 16'h0000);
    exp_cnt++;
    frame_check(0, 16'h0000, 50, 1'b0, 2'd0, 16'h0000);
    exp_cnt++;
    tick();
    check_idle("after continuous");

    // Randomized back-to-back chain; next frame's settings change mid-frame.
    cur_md = 2'($urandom_range(0, 3));
    cur_sc = 16'($urandom);
    start_frame(cur_md, cur_sc, 1'b1);
    for (int f = 0; f < 6; f++) begin
      nxt_md = 2'($urandom_range(0, 3));
      nxt_sc = 16'($urandom);
      frame_check(int'(cur_md), cur_sc, $urandom_range(0, FT - 2), (f != 5), nxt_md, nxt_sc);
      exp_cnt++;
      cur_md = nxt_md;
      cur_sc = nxt_sc;
    end
    tick();
    check_idle("after random");

    // Frame counter wrap from FFFF.
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    exp_cnt = 16'hFFFF;
    start_frame(2'd3, 16'h0000, 1'b0);
    frame_check(3, 16'h0000, -1, 1'b0, 2'd3, 16'h0000);
    exp_cnt++;
    tick();
    check_idle("after wrap");
    check("wrapped count", frame_cnt, 16'h0000);

    // Reset in the middle of a line.
    start_frame(2'd1, 16'h0000, 1'b0);
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    exp_cnt = 16'h0000;
    check_idle("mid-frame reset");
    rst_n = 1'b1;
    repeat (20) begin
      tick();
      check_idle("post reset idle");
    end
    start_frame(2'd2, 16'h5A5A, 1'b0);
    frame_check(2, 16'h5A5A, -1, 1'b0, 2'd2, 16'h5A5A);
    exp_cnt++;
    tick();
    check_idle("after reset frame");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
